// File: rtl/bin_pool_pkg.sv
// Shared types and geometry helpers for the binarize/max-pool stage and the conv stage feeding it.
package bin_pool_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Input feature-map widths of the two layers
    localparam int NI_L1 = 28;
    localparam int NI_L2 = 12;

    // Valid conv outputs per row for an Ni-wide input and KxK kernel
    function automatic int conv_w(input int ni, input int k);
        return ni - k + 1;
    endfunction

    function automatic int pool_w(input int ni, input int k, input int p);
        return conv_w(ni, k) / p;
    endfunction

endpackage

// File: rtl/bin_pool_if.sv
// Stream-in / pooled-pixel-out signal bundle of bin_pool.
interface bin_pool_if;
    logic              start;
    logic              state;
    logic signed [4:0] threshold;
    logic signed [4:0] din;
    logic              ivalid;
    logic              pool_out;
    logic              pool_valid;
    logic              pool_done;
    logic              frame_err;

    modport master (
        output start, state, threshold, din, ivalid,
        input  pool_out, pool_valid, pool_done, frame_err
    );

    modport slave (
        input  start, state, threshold, din, ivalid,
        output pool_out, pool_valid, pool_done, frame_err
    );
endinterface

// File: rtl/pool_rowbuf.sv
// One-bit-per-entry row buffer holding the horizontal OR pairs of the even conv row.
module pool_rowbuf #(
    parameter int DEPTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic          wdata,
    output logic          rdata
);

    logic [DEPTH-1:0] mem_q, mem_d;

    // Writes happen on even rows and reads on odd rows, so no bypass is needed
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[idx] = wdata;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/bin_pool.sv
// Binarizes the conv stream against a threshold and 2x2 OR-pools it in raster order.
module bin_pool
    import bin_pool_pkg::*;
#(
    parameter int K = 3,
    parameter int P = 2
) (
    input logic       clk,
    input logic       rstn,
    bin_pool_if.slave bus
);

    localparam int W1  = conv_w(NI_L1, K);
    localparam int W2  = conv_w(NI_L2, K);
    localparam int PW1 = pool_w(NI_L1, K, P);
    localparam int CW  = $clog2(W1);
    localparam int AW  = $clog2(PW1);

    fsm_e          fsm_q, fsm_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          pair_lo_q, pair_lo_d;
    logic          lyr_q, lyr_d;
    logic          pool_out_q, pool_out_d;
    logic          pool_valid_q, pool_valid_d;
    logic          pool_done_q, pool_done_d;
    logic          frame_err_q, frame_err_d;

    logic          b, h;
    logic [CW-1:0] w_last;
    logic          col_last, row_last;
    logic          rb_we, rb_rdata;

    assign b        = (bus.din >= bus.threshold);
    assign h        = pair_lo_q | b;
    assign w_last   = lyr_q ? CW'(W2 - 1) : CW'(W1 - 1);
    assign col_last = (col_q == w_last);
    assign row_last = (row_q == w_last);
    assign rb_we    = (fsm_q == RUN) && bus.start && bus.ivalid && col_q[0] && !row_q[0];

    pool_rowbuf #(.DEPTH(PW1), .AW(AW)) u_rowbuf (
        .clk   (clk),
        .we    (rb_we),
        .idx   (col_q[AW:1]),
        .wdata (h),
        .rdata (rb_rdata)
    );

    always_comb begin
        fsm_d        = fsm_q;
        col_d        = col_q;
        row_d        = row_q;
        pair_lo_d    = pair_lo_q;
        lyr_d        = lyr_q;
        pool_out_d   = 1'b0;
        pool_valid_d = 1'b0;
        pool_done_d  = 1'b0;
        frame_err_d  = frame_err_q;

        if (!bus.start) begin
            fsm_d     = IDLE;
            col_d     = '0;
            row_d     = '0;
            pair_lo_d = 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    fsm_d       = RUN;
                    lyr_d       = bus.state;
                    frame_err_d = 1'b0;
                    col_d       = '0;
                    row_d       = '0;
                    pair_lo_d   = 1'b0;
                end
                RUN: begin
                    if (bus.ivalid) begin
                        if (!col_q[0]) begin
                            pair_lo_d = b;
                        end else if (row_q[0]) begin
                            pool_valid_d = 1'b1;
                            pool_out_d   = rb_rdata | h;
                        end
                        if (col_last) begin
                            col_d = '0;
                            if (row_last) begin
                                row_d = '0;
                                fsm_d = DONE;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Only the first DONE cycle sees the final pixel's valid still registered
                    pool_done_d = pool_valid_q;
                    if (bus.ivalid) frame_err_d = 1'b1;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fsm_q        <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pair_lo_q    <= 1'b0;
            lyr_q        <= 1'b0;
            pool_out_q   <= 1'b0;
            pool_valid_q <= 1'b0;
            pool_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pair_lo_q    <= pair_lo_d;
            lyr_q        <= lyr_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            pool_done_q  <= pool_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.pool_out   = pool_out_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_done  = pool_done_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: doc/bin_pool.md
BIN_POOL -- requirements
Module: bin_pool

Interface
REQ-001 The block SHALL have parameter K, default 3, meaning the convolution kernel size; valid samples per row = Ni-K+1.
REQ-002 The block SHALL have parameter P, default 2, meaning the pooling window and stride; only P=2 is supported.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  frame enable; held high for the whole frame, low returns the block to IDLE.
REQ-006 state  input  1  layer select: 0 = layer 1 (Ni=28, 26x26 conv map, 13x13 pooled); 1 = layer 2 (Ni=12, 10x10 conv map, 5x5 pooled).
REQ-007 threshold  input  5 signed  binarization threshold.
REQ-008 din  input  5 signed  upstream conv result.
REQ-009 ivalid  input  1  din qualifier; rows arrive as Ni-K+1 valid cycles with arbitrary gaps between them.
REQ-010 pool_out  output  1  binary pooled pixel.
REQ-011 pool_valid  output  1  single-cycle pool_out qualifier.
REQ-012 pool_done  output  1  single-cycle pulse after the last pooled pixel of a frame.
REQ-013 frame_err  output  1  sticky overrun flag.

Function
REQ-014 Binarization SHALL be b = (din >= threshold), using a signed 5-bit compare with no sign extension loss.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
  - IDLE->RUN on start high; state is latched on this transition and ignored for the rest of the frame.
  - RUN->DONE when the last pooled pixel is emitted.
  - Any state->IDLE when start is low.
REQ-016 In IDLE, ivalid SHALL be ignored and all counters held at 0.
REQ-017 col counter: increments on each ivalid in RUN; wraps to 0 after W-1, where W = Ni-K+1 (26 or 10).
REQ-018 row counter: increments on each col wrap; reaching W-1 with a col wrap marks the frame complete.
REQ-019 On even col, the block SHALL register b as pair_lo.
REQ-020 On odd col, the horizontal pair h = pair_lo | b.
REQ-021 On an even row, h SHALL be written to a row buffer of W/2 bits (13 or 5) at index col>>1.
REQ-022 On an odd row, pool_out SHALL be row_buf[col>>1] | h with pool_valid high, registered exactly 1 cycle after the ivalid cycle that completed the 2x2 window.
REQ-023 Pooled pixels SHALL emit in raster order: 169 per frame for state=0, 25 for state=1.
REQ-024 pool_done SHALL pulse 1 cycle after the final pool_valid, i.e. 2 cycles after the last ivalid.
REQ-025 ivalid in DONE SHALL be dropped and SHALL set frame_err.
  - frame_err clears only on an IDLE->RUN transition or reset.
REQ-026 start falling mid-frame SHALL abort the frame.
  - IDLE on the next cycle, counters cleared, no pool_valid or pool_done; row buffer contents are don't-care.
REQ-027 pool_out SHALL be 0 whenever pool_valid is 0.

Reset
REQ-028 On rstn low at a clock edge, the block SHALL enter IDLE.
  - col, row, pair_lo and the latched state are set to 0.
  - pool_out, pool_valid, pool_done and frame_err are set to 0.
  - The row buffer need not be reset.
REQ-029 Reset SHALL take priority over start and ivalid in the same cycle.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding, the Ni constants (28, 12), and W/pooled-size derivation functions, shared with the conv stage.
REQ-031 One sub-module SHALL be used: pool_rowbuf, a (W/2)-bit register file.
  - 1 write port and 1 read port, same index, write-first not required (read and write never target the same row parity).
REQ-032 The implementation SHALL not exceed 400 lines of RTL and SHALL use no multipliers.

Verification
REQ-033 Scenario: state=0, threshold=0, all din=+1 for 676 contiguous valid cycles -> 169 pool_valid, all pool_out=1, pool_done 2 cycles after the last ivalid.
REQ-034 Scenario: state=1, threshold=0, din=-1 everywhere except conv(3,5)=+3 -> 25 outputs, only pooled pixel (1,2) equals 1.
REQ-035 Scenario: state=1, threshold=-2, din=-2 at one position, -3 elsewhere, 3-cycle gaps between rows -> exactly one pooled 1; output timing is unaffected by the gaps.
REQ-036 Scenario: state=0, start dropped after row 7 -> no further pool_valid or pool_done; a new state=1 frame then yields exactly 25 correct outputs.
REQ-037 Scenario: state=1 frame completes, then 1 extra ivalid -> frame_err=1 and it stays set; the next start clears it.
REQ-038 Scenario: rstn low for 1 cycle mid-frame with ivalid high -> all outputs 0 on the next cycle, FSM in IDLE.
